// File: rtl/orient_hist_peak.sv
// orient_hist_peak
// Dominant-orientation finder: accumulates a 32-bin saturating orientation
// histogram from a stream of (bin, magnitude) samples. It then scans the
// histogram for the peak, where a tie goes to the lowest bin. The peak bin and
// its weight are held until downstream accepts them.
module orient_hist_peak #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_bin,
    input  logic [MAG_W-1:0] in_mag,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_bin,
    output logic [ACC_W-1:0] out_peak
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Saturating accumulate: clamp at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [MAG_W-1:0] mag);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W+1)'(mag);
        if (sum[ACC_W]) begin
            sat_add = {ACC_W{1'b1}};
        end else begin
            sat_add = sum[ACC_W-1:0];
        end
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_hist [32];
    logic [4:0]         r_idx;
    logic               r_scan_last;
    logic [ACC_W-1:0]   r_best_val;
    logic [4:0]         r_best_bin;
    logic               r_out_valid;
    logic [4:0]         r_out_bin;
    logic [ACC_W-1:0]   r_out_peak;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_handshake;
    logic               w_scan_step;
    logic [ACC_W-1:0]   w_hist_cur;

    assign w_hist_cur = r_hist[r_idx];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: last sample starts the scan, the scan ends one cycle
    // after bin 31 is compared, and the output handshake reopens the input.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && in_last) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_SCAN: begin
                if (r_scan_last) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        w_in_ready  = 1'b0;
        w_scan_step = 1'b0;
        case (r_state)
            ST_ACCUM: w_in_ready  = 1'b1;
            ST_SCAN:  w_scan_step = !r_scan_last;
            ST_HOLD:  w_in_ready  = 1'b0;
            default:  w_in_ready  = 1'b0;
        endcase
        w_accept    = in_valid && w_in_ready;
        w_handshake = r_out_valid && out_ready;
    end

    // Histogram bins: saturating accumulate on accept, bulk clear on result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_hist[i] <= {ACC_W{1'b0}};
            end
        end else if (w_accept) begin
            r_hist[in_bin] <= sat_add(r_hist[in_bin], in_mag);
        end else if (w_handshake) begin
            for (int i = 0; i < 32; i++) begin
                r_hist[i] <= {ACC_W{1'b0}};
            end
        end
    end

    // Scan index and running maximum; strict compare keeps the lowest bin on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= 5'd0;
            r_scan_last <= 1'b0;
            r_best_val  <= {ACC_W{1'b0}};
            r_best_bin  <= 5'd0;
        end else if (w_scan_step) begin
            if (r_idx == 5'd0) begin
                r_best_val <= w_hist_cur;
                r_best_bin <= 5'd0;
            end else if (w_hist_cur > r_best_val) begin
                r_best_val <= w_hist_cur;
                r_best_bin <= r_idx;
            end
            if (r_idx == 5'd31) begin
                r_scan_last <= 1'b1;
                r_idx       <= 5'd0;
            end else begin
                r_idx <= r_idx + 5'd1;
            end
        end else if (r_state == ST_SCAN) begin
            r_scan_last <= 1'b0;
        end
    end

    // Result registers: loaded when the scan completes, retained after handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_bin   <= 5'd0;
            r_out_peak  <= {ACC_W{1'b0}};
        end else begin
            r_out_valid <= (w_state_nxt == ST_HOLD);
            if (r_state == ST_SCAN && r_scan_last) begin
                r_out_bin  <= r_best_bin;
                r_out_peak <= r_best_val;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_bin   = r_out_bin;
    assign out_peak  = r_out_peak;

endmodule

// File: tb/tb_orient_hist_peak.sv
// Self-checking bench for orient_hist_peak: directed scenarios plus randomized
// windows compared against a plain-arithmetic histogram/peak model.
module tb_orient_hist_peak;

    localparam int MAG_W   = 8;
    localparam int ACC_W   = 16;
    localparam int SAT_MAX = 65535;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_bin;
    logic [MAG_W-1:0] in_mag;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_bin;
    logic [ACC_W-1:0] out_peak;

    int vectors;
    int miscompares;
    int m_hist [32];

    orient_hist_peak #(.MAG_W(MAG_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .in_mag    (in_mag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_peak  (out_peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: histogram of sums clamped at the accumulator maximum.
    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_hist[i] = 0;
    endtask

    task automatic model_add(input int b, input int m);
        m_hist[b] = (m_hist[b] + m > SAT_MAX) ? SAT_MAX : m_hist[b] + m;
    endtask

    // Highest weight wins; the first (lowest) bin reaching it is kept.
    task automatic model_peak(output int b, output int p);
        b = 0;
        p = m_hist[0];
        for (int i = 1; i < 32; i++) begin
            if (m_hist[i] > p) begin
                b = i;
                p = m_hist[i];
            end
        end
    endtask

    task automatic send(input int b, input int m, input bit last);
        in_bin   = 5'(b);
        in_mag   = 8'(m);
        in_last  = last;
        in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_ready: in_ready=%0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_add(b, m);
    endtask

    // Called right after the last sample's accept edge; checks exact latency and result.
    task automatic wait_result(input string name);
        int eb;
        int ep;
        bit early;
        model_peak(eb, ep);
        early = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) early = 1'b1;
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("FAIL %s_scan: out_valid/in_ready not both 0 during scan, expected 0", name);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_latency: out_valid=%0b at T+33 expected 1", name, out_valid);
        end
        vectors++;
        if (out_bin !== 5'(eb)) begin
            miscompares++;
            $display("FAIL %s_bin: out_bin=%0d expected %0d", name, out_bin, eb);
        end
        vectors++;
        if (out_peak !== 16'(ep)) begin
            miscompares++;
            $display("FAIL %s_peak: out_peak=%0d expected %0d", name, out_peak, ep);
        end
    endtask

    task automatic handshake(input string name);
        int eb;
        int ep;
        model_peak(eb, ep);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_hs: out_valid=%0b in_ready=%0b expected 0/1", name, out_valid, in_ready);
        end
        vectors++;
        if (out_bin !== 5'(eb) || out_peak !== 16'(ep)) begin
            miscompares++;
            $display("FAIL %s_retain: bin=%0d peak=%0d expected %0d/%0d", name, out_bin, out_peak, eb, ep);
        end
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bin !== 5'd0 || out_peak !== 16'd0) begin
            miscompares++;
            $display("FAIL reset: rdy=%0b vld=%0b bin=%0d peak=%0d expected 1/0/0/0",
                     in_ready, out_valid, out_bin, out_peak);
        end
        model_clear();
    endtask

    task automatic test_single();
        send(7, 200, 1'b1);
        wait_result("single");
        handshake("single");
    endtask

    task automatic test_tie();
        send(3, 10, 1'b0);
        send(20, 40, 1'b0);
        send(3, 35, 1'b0);
        send(20, 5, 1'b1);
        wait_result("tie");
        handshake("tie");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 299; i++) send(31, 255, 1'b0);
        send(31, 255, 1'b1);
        wait_result("saturate");
        handshake("saturate");
    endtask

    task automatic test_back_to_back();
        send(9, 100, 1'b0);
        send(9, 101, 1'b0);
        send(9, 102, 1'b0);
        send(0, 250, 1'b0);
        send(9, 1, 1'b1);
        wait_result("b2b");
        handshake("b2b");
    endtask

    task automatic test_backpressure();
        bit bad;
        send(14, 77, 1'b0);
        send(2, 60, 1'b1);
        wait_result("bp");
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bin   = 5'($urandom_range(0, 31));
            in_mag   = 8'($urandom_range(1, 255));
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bin !== 5'd14 || out_peak !== 16'd77)
                bad = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL bp_hold: output not stable while stalled, expected bin 14 peak 77");
        end
        handshake("bp");
        send(5, 9, 1'b1);
        wait_result("bp_next");
        handshake("bp_next");
    endtask

    task automatic test_zero();
        send(17, 0, 1'b1);
        wait_result("zero");
        handshake("zero");
    endtask

    task automatic test_reset_mid_scan();
        bit bad;
        send(20, 250, 1'b0);
        send(12, 100, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_scan_async: vld=%0b rdy=%0b expected 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL rst_scan_idle: output produced or input closed after reset, expected idle");
        end
        send(12, 1, 1'b1);
        wait_result("rst_next");
        handshake("rst_next");
    endtask

    task automatic test_random();
        int len;
        int span;
        for (int w = 0; w < 12; w++) begin
            len  = $urandom_range(1, 40);
            span = ($urandom_range(0, 1) == 0) ? 3 : 31;
            for (int k = 0; k < len; k++) begin
                send($urandom_range(0, span), $urandom_range(0, 255), k == len - 1);
            end
            wait_result("random");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            handshake("random");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_bin      = 5'd0;
        in_mag      = 8'd0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        model_clear();
        test_reset();
        test_single();
        test_tie();
        test_saturate();
        test_back_to_back();
        test_backpressure();
        test_zero();
        test_reset_mid_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
